lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store unit driving a word-wide memory with one-cycle read latency.
// Optional LSU_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of silently aligning them.
module lsu_mem_master (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        mem_wr_enable_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DATA, S_WR, S_RESP} state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_rd_addr;

  logic        w_is_word;
  logic        w_is_half;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_is_word = req_size_i[1];
  assign w_is_half = (req_size_i == 2'b01);

  // Lane offset is forced down to the access size's natural alignment.
  always_comb begin
    w_off = req_addr_i[1:0];
    if (w_is_word)
      w_off = 2'b00;
    else if (w_is_half)
      w_off = {req_addr_i[1], 1'b0};
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_resp_err;
  assign w_misalign = (w_is_half && req_addr_i[0]) ||
                      (w_is_word && (req_addr_i[1:0] != 2'b00));
  assign resp_err_o = r_resp_err;
`else
  assign w_misalign = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  always_comb begin
    unique case (r_off)
      2'd0: w_byte = mem_rd_data_i[7:0];
      2'd1: w_byte = mem_rd_data_i[15:8];
      2'd2: w_byte = mem_rd_data_i[23:16];
      2'd3: w_byte = mem_rd_data_i[31:24];
    endcase
    w_half = r_off[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    if (r_size[1])
      w_load = mem_rd_data_i;
    else if (r_size[0])
      w_load = {{16{r_signed & w_half[15]}}, w_half};
    else
      w_load = {{24{r_signed & w_byte[7]}}, w_byte};
  end

  // Read-modify-write: only the addressed lane takes store data.
  always_comb begin
    w_merge = mem_rd_data_i;
    if (r_size[1]) begin
      w_merge = r_wdata;
    end else if (r_size[0]) begin
      if (r_off[1])
        w_merge[31:16] = r_wdata[15:0];
      else
        w_merge[15:0] = r_wdata[15:0];
    end else begin
      unique case (r_off)
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_addr        <= 32'h0;
      r_off         <= 2'b00;
      r_wdata       <= 32'h0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_mem_rd_addr <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
      r_resp_err    <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_size   <= req_size_i;
            r_signed <= req_signed_i;
            r_addr   <= {req_addr_i[31:2], 2'b00};
            r_off    <= w_off;
            r_wdata  <= req_wdata_i;
            if (w_misalign) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
              r_resp_err   <= 1'b1;
`endif
            end else if (req_we_i && w_is_word) begin
              r_state <= S_WR;
            end else begin
              r_state       <= S_RD;
              r_mem_rd_addr <= {req_addr_i[31:2], 2'b00};
            end
          end
        end
        S_RD: r_state <= S_DATA;
        S_DATA: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_we ? 32'h0 : w_load;
`ifdef LSU_MISALIGN_CHECK_EN
          r_resp_err   <= 1'b0;
`endif
        end
        S_WR: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
          r_resp_err   <= 1'b0;
`endif
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (r_state == S_IDLE);
  assign resp_valid_o    = r_resp_valid;
  assign resp_rdata_o    = r_resp_rdata;
  assign mem_rd_addr_o   = r_mem_rd_addr;
  assign mem_wr_addr_o   = r_addr;
  assign mem_wr_data_o   = (r_state == S_WR) ? r_wdata : w_merge;
  assign mem_wr_enable_o = (r_state == S_WR) || ((r_state == S_DATA) && r_we);

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected responses, a negedge monitor checks them.
module tb_lsu_mem_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic [31:0] mem_wr_addr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_wr_enable_o;

  lsu_mem_master dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_enable_o(mem_wr_enable_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] mem [0:1023];
  int          cyc = 0;
  int          wr_count = 0;
  int          last_wr_cyc = -1;
  int          n_vec = 0;
  int          n_err = 0;

  // Memory model: registered read, write sampled at posedge.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    mem_rd_data_i <= mem[mem_rd_addr_o[11:2]];
    if (mem_wr_enable_o)
      mem[mem_wr_addr_o[11:2]] <= mem_wr_data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (mem_wr_enable_o) begin
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (resp_valid_o) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got rdata %h err %b with no response expected (cycle %0d)",
                 resp_rdata_o, resp_err_o, cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [31:0] peek(input logic [31:0] addr);
    return mem[addr[11:2]];
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input bit hold, output int acc);
    int t;
    exp_t x;
    t = 0;
    acc = -1;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    while (!req_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (!req_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got req_ready_o 0 for 20 cycles, expected 1 (addr %h)", addr);
      req_valid_i = 1'b0;
    end else begin
      acc = cyc;
      x.rdata = exp_rdata;
      x.err   = exp_err;
      x.cyc   = cyc + lat;
      sbq.push_back(x);
      @(posedge clk_i);
      @(negedge clk_i);
      if (!hold) req_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, w0;
    reset_i      = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = 2'b00;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err_o}, 32'd0);
    chk("rst_wr_enable", {31'b0, mem_wr_enable_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_rd_addr", mem_rd_addr_o, 32'h0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Word store then word load.
    w0 = wr_count;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0, a1);
    drain();
    chk("st_word_writes", 32'(wr_count - w0), 32'd1);
    chk("st_word_wr_cycle", 32'(last_wr_cyc), 32'(a1 + 1));
    chk("mem_100", peek(32'h100), 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, a1);
    drain();

    issue(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 32'h0, 1'b0, 2, 1'b0, a1);
    issue(1'b1, 2'b11, 1'b0, 32'h300, 32'hAABBCCDD, 32'h0, 1'b0, 2, 1'b0, a1);
    drain();
    chk("mem_300", peek(32'h300), 32'hAABBCCDD);

    // Byte lanes and extension.
    issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h00000011, 1'b0, 3, 1'b0, a1);
    w0 = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h55AA0080, 32'h0, 1'b0, 3, 1'b0, a1);
    drain();
    chk("st_byte_writes", 32'(wr_count - w0), 32'd1);
    chk("mem_200", peek(32'h200), 32'h11228044);
    issue(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0, a1);
    issue(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h00000080, 1'b0, 3, 1'b0, a1);
    issue(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'hFFFF8044, 1'b0, 3, 1'b0, a1);
    issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h00001122, 1'b0, 3, 1'b0, a1);
    issue(1'b0, 2'b11, 1'b1, 32'h200, 32'h0, 32'h11228044, 1'b0, 3, 1'b0, a1);
    drain();

    // Half store read-modify-write.
    w0 = wr_count;
    issue(1'b1, 2'b01, 1'b0, 32'h302, 32'hFFFF1234, 32'h0, 1'b0, 3, 1'b0, a1);
    drain();
    chk("st_half_writes", 32'(wr_count - w0), 32'd1);
    chk("st_half_wr_cycle", 32'(last_wr_cyc), 32'(a1 + 2));
    chk("mem_300_half", peek(32'h300), 32'h1234CCDD);

    // Misaligned accesses.
    w0 = wr_count;
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b0, a1);
    issue(1'b0, 2'b01, 1'b0, 32'h303, 32'h0, 32'h0, 1'b1, 1, 1'b0, a1);
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, 32'h0, 1'b1, 1, 1'b0, a1);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, a1);
    issue(1'b0, 2'b01, 1'b0, 32'h303, 32'h0, 32'h00001234, 1'b0, 3, 1'b0, a1);
`endif
    drain();
    chk("misalign_no_write", 32'(wr_count - w0), 32'd0);
    chk("mem_100_kept", peek(32'h100), 32'hDEADBEEF);

    // Reset asserted in DATA of a half store.
    w0 = wr_count;
    req_we_i     = 1'b1;
    req_size_i   = 2'b01;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h300;
    req_wdata_i  = 32'h0000BEEF;
    req_valid_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("busy_not_ready", {31'b0, req_ready_o}, 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    chk("abort_ready", {31'b0, req_ready_o}, 32'd1);
    chk("abort_wr_enable", {31'b0, mem_wr_enable_o}, 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("abort_writes", 32'(wr_count - w0), 32'd0);
    chk("abort_mem_300", peek(32'h300), 32'h1234CCDD);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h1234CCDD, 1'b0, 3, 1'b0, a1);
    drain();

    // Back-to-back loads with valid held.
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, a1);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h11228044, 1'b0, 3, 1'b0, a2);
    drain();
    chk("b2b_accept_cycle", 32'(a2), 32'(a1 + 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
